// File: rtl/apb_completer_if.sv
// APB4 bus bundle between a requester and the apb_completer register bank.
// The master modport is the requester side and the slave modport is the completer side.
interface apb_completer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
);
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [DATA_WIDTH-1:0] PWDATA;
   logic [STRB_WIDTH-1:0] PSTRB;
   logic [2:0]            PPROT;
   logic [DATA_WIDTH-1:0] PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_completer.sv
// APB4 completer with a programmable wait-state count and a small register bank.
// Register 0 holds a read-only ID. The upper half of the bank is privileged.
module apb_completer #(
   parameter int                   ADDR_WIDTH  = 32,
   parameter int                   DATA_WIDTH  = 32,
   parameter int                   STRB_WIDTH  = DATA_WIDTH / 8,
   parameter int                   NUM_REGS    = 16,
   parameter int                   WAIT_CYCLES = 1,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA0B4_0001
) (
   input  logic             clk,
   input  logic             rst_n,
   apb_completer_if.slave   bus
);
   localparam int IDX_W = $clog2(NUM_REGS);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                 state_reg, state_next;
   logic [3:0]             cnt_reg, cnt_next;
   logic                   capture;
   logic                   done;

   logic [ADDR_WIDTH-1:0]  addr_reg;
   logic                   write_reg;
   logic [DATA_WIDTH-1:0]  wdata_reg;
   logic [STRB_WIDTH-1:0]  strb_reg;
   logic                   priv_reg;

   logic [IDX_W-1:0]       idx;
   logic                   err;
   logic                   commit;
   logic [DATA_WIDTH-1:0]  wmask;
   logic [DATA_WIDTH-1:0]  rd_word;
   logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            // PSEL with PENABLE already high is not a valid setup phase.
            if (bus.PSEL && !bus.PENABLE) begin
               state_next = ACCESS;
               cnt_next   = 4'(WAIT_CYCLES);
               capture    = 1'b1;
            end
         end
         ACCESS: begin
            if (!bus.PSEL) begin
               state_next = IDLE;
            end else if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg  <= '0;
         write_reg <= 1'b0;
         wdata_reg <= '0;
         strb_reg  <= '0;
         priv_reg  <= 1'b0;
      end else if (capture) begin
         addr_reg  <= bus.PADDR;
         write_reg <= bus.PWRITE;
         wdata_reg <= bus.PWDATA;
         strb_reg  <= bus.PSTRB;
         priv_reg  <= bus.PPROT[0];
      end
   end

   // All decode works on the captured copy, so bus changes during ACCESS are harmless.
   always_comb begin
      idx = addr_reg[IDX_W+1:2];
      err = (addr_reg[1:0] != 2'b00)
          | (addr_reg[ADDR_WIDTH-1:IDX_W+2] != '0)
          | (write_reg && (idx == '0))
          | (!priv_reg && idx[IDX_W-1]);
   end

   for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{strb_reg[gi]}};
   end

   assign commit = done && write_reg && !err;

   // Entry 0 is never written; reads of index 0 are served from ID_VALUE instead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[idx] <= (regs[idx] & ~wmask) | (wdata_reg & wmask);
      end
   end

   always_comb begin
      rd_word     = (idx == '0) ? ID_VALUE : regs[idx];
      bus.PREADY  = done;
      bus.PSLVERR = done && err;
      bus.PRDATA  = (done && !write_reg && !err) ? rd_word : '0;
   end
endmodule

// File: tb/tb_apb_completer.sv
// Randomized bench for apb_completer: three instances (1, 0 and 3 wait states) checked
// against a per-instance register-bank model derived from the address/protection rules.
module tb_apb_completer;
   localparam logic [31:0] ID = 32'hA0B4_0001;

   logic        clk;
   logic        rst_n;
   logic        psel    [3];
   logic        penable [3];
   logic        pwrite  [3];
   logic [31:0] paddr   [3];
   logic [31:0] pwdata  [3];
   logic [3:0]  pstrb   [3];
   logic [2:0]  pprot   [3];
   logic [31:0] prdata  [3];
   logic        pready  [3];
   logic        pslverr [3];

   logic [31:0] mdl [3][16];
   int          n_checks;
   int          n_fail;

   function automatic int wait_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int WC = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
      apb_completer_if bus ();
      assign bus.PSEL    = psel[gi];
      assign bus.PENABLE = penable[gi];
      assign bus.PWRITE  = pwrite[gi];
      assign bus.PADDR   = paddr[gi];
      assign bus.PWDATA  = pwdata[gi];
      assign bus.PSTRB   = pstrb[gi];
      assign bus.PPROT   = pprot[gi];
      assign prdata[gi]  = bus.PRDATA;
      assign pready[gi]  = bus.PREADY;
      assign pslverr[gi] = bus.PSLVERR;

      apb_completer #(.WAIT_CYCLES(WC)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 16; i++)
            mdl[d][i] = 32'h0;
   endtask

   // One complete transfer starting at posedge+1; returns at posedge+1 of the cycle after PREADY.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       output logic [31:0] rdata, output logic err);
      int          n;
      int          idx;
      bit          exp_err;
      logic [31:0] exp_rd;
      idx     = (addr < 64) ? int'(addr / 4) : 0;
      exp_err = (addr % 4 != 0) || (addr >= 64) || (wr && idx == 0) || (!prot[0] && idx >= 8);
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wdata;
      pstrb[d]   = strb;
      pprot[d]   = prot;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      paddr[d]   = $urandom;
      pwdata[d]  = $urandom;
      pstrb[d]   = 4'($urandom);
      pprot[d]   = ~prot;
      pwrite[d]  = ~wr;
      n = 1;
      while (!pready[d] && n < 40) begin
         check("wait_prdata", prdata[d], 32'h0);
         check("wait_pslverr", 32'(pslverr[d]), 32'h0);
         @(posedge clk); #1;
         n++;
      end
      check("latency", 32'(n), 32'(wait_of(d) + 1));
      rdata = prdata[d];
      err   = pslverr[d];
      check("pslverr", 32'(err), 32'(exp_err));
      if (!wr) begin
         exp_rd = exp_err ? 32'h0 : ((idx == 0) ? ID : mdl[d][idx]);
         check("prdata", rdata, exp_rd);
      end else if (!exp_err) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
      $display("dut%0d %s addr=%h wdata=%h strb=%b prot=%b -> rdata=%h err=%0d cycles=%0d",
               d, wr ? "WR" : "RD", addr, wdata, strb, prot, rdata, err, n);
      @(posedge clk); #1;
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] a;
      n_checks = 0;
      n_fail   = 0;
      clear_model();
      for (int d = 0; d < 3; d++) begin
         psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; paddr[d] = '0;
         pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_pready", 32'(pready[d]), 32'h0);
         check("rst_prdata", prdata[d], 32'h0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases on the one-wait-state instance.
      xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, rd, er);
      check("id_read", rd, ID);
      check("id_err", 32'(er), 32'h0);
      xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'b0101, 3'b001, rd, er);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, 3'b001, rd, er);
      check("strb_read", rd, 32'h00AD_00EF);
      xfer(0, 1, 32'h0, 32'h1111_1111, 4'hF, 3'b001, rd, er);
      check("id_write_err", 32'(er), 32'h1);
      xfer(0, 0, 32'h2, 32'h0, 4'hF, 3'b001, rd, er);
      check("misalign_err", 32'(er), 32'h1);
      check("misalign_data", rd, 32'h0);
      xfer(0, 0, 32'h40, 32'h0, 4'hF, 3'b001, rd, er);
      check("range_err", 32'(er), 32'h1);
      check("range_data", rd, 32'h0);
      xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b001, rd, er);
      check("id_unchanged", rd, ID);
      xfer(0, 1, 32'h20, 32'h1234_5678, 4'hF, 3'b000, rd, er);
      check("unpriv_err", 32'(er), 32'h1);
      xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er);
      check("unpriv_nowrite", rd, 32'h0);
      xfer(0, 1, 32'h20, 32'h1234_5678, 4'hF, 3'b001, rd, er);
      check("priv_ok", 32'(er), 32'h0);
      xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b001, rd, er);
      check("priv_read", rd, 32'h1234_5678);

      // Back-to-back write then read on the zero- and three-wait instances.
      xfer(1, 1, 32'h8, 32'h5A5A_C3C3, 4'hF, 3'b000, rd, er);
      xfer(1, 0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er);
      check("b2b_w0", rd, 32'h5A5A_C3C3);
      xfer(2, 1, 32'h8, 32'h0F1E_2D3C, 4'hF, 3'b000, rd, er);
      xfer(2, 0, 32'h8, 32'h0, 4'h0, 3'b000, rd, er);
      check("b2b_w3", rd, 32'h0F1E_2D3C);

      for (int d = 0; d < 3; d++) begin
         for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
               7:       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
               8:       a = 32'(64 + $urandom_range(0, 255) * 4);
               9:       a = $urandom;
               default: a = 32'($urandom_range(0, 15) * 4);
            endcase
            xfer(d, 1'($urandom), a, $urandom, 4'($urandom), 3'($urandom), rd, er);
         end
      end

      // PSEL+PENABLE in IDLE is not a setup phase.
      psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 32'h0;
      repeat (2) begin
         @(posedge clk); #1;
         check("bad_setup_pready", 32'(pready[0]), 32'h0);
      end
      psel[0] = 1'b0; penable[0] = 1'b0;
      @(posedge clk); #1;

      // Requester drops PSEL mid-ACCESS: no write, no response.
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h8;
      pwdata[2] = 32'hCAFE_F00D; pstrb[2] = 4'hF; pprot[2] = 3'b001;
      @(posedge clk); #1;
      penable[2] = 1'b1;
      @(posedge clk); #1;
      psel[2] = 1'b0; penable[2] = 1'b0;
      #1;
      check("abort_pready", 32'(pready[2]), 32'h0);
      @(posedge clk); #1;
      xfer(2, 0, 32'h8, 32'h0, 4'h0, 3'b001, rd, er);
      check("abort_nowrite", rd, mdl[2][2]);

      // Asynchronous reset during a completing read (dut1) and a waiting write (dut2).
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h0; pprot[1] = 3'b001;
      psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'hC;
      pwdata[2] = 32'h7777_7777; pstrb[2] = 4'hF; pprot[2] = 3'b001;
      @(posedge clk); #1;
      penable[1] = 1'b1; penable[2] = 1'b1;
      check("pre_rst_pready", 32'(pready[1]), 32'h1);
      check("pre_rst_prdata", prdata[1], ID);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_pready", 32'(pready[1]), 32'h0);
      check("rst_async_prdata", prdata[1], 32'h0);
      check("rst_async_w3", 32'(pready[2]), 32'h0);
      psel[1] = 1'b0; penable[1] = 1'b0; psel[2] = 1'b0; penable[2] = 1'b0;
      clear_model();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(2, 0, 32'hC, 32'h0, 4'h0, 3'b001, rd, er);
      check("rst_nowrite", rd, 32'h0);
      xfer(1, 0, 32'h8, 32'h0, 4'h0, 3'b001, rd, er);
      check("rst_cleared", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
